// File: rtl/alu_cmd_pkg.sv
// Shared types for the ALU command sequencer: opcodes, command word layout,
// FSM state encoding and flag-vector bit positions.
package alu_cmd_pkg;

   typedef logic [2:0] opcode_t;

   localparam opcode_t OP_SUB = 3'b001;
   localparam opcode_t OP_CAS = 3'b111;

   // 12-bit command word as seen by the ALU controller
   typedef struct packed {
      opcode_t    op;
      logic [2:0] a1;
      logic [2:0] a2;
      logic [2:0] a3;
   } cmd_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_ISSUE,
      S_WAIT,
      S_CHECK,
      S_DONE
   } state_e;

   // flags vector is {O,C,Z,N}
   localparam int FLAG_O = 3;
   localparam int FLAG_C = 2;
   localparam int FLAG_Z = 1;
   localparam int FLAG_N = 0;

endpackage

// File: rtl/cmd_prog_ram.sv
// Program store: DEPTH x 12 bits, one write port, registered read port.
// Contents are deliberately not reset so a program survives a reset.
module cmd_prog_ram
   import alu_cmd_pkg::*;
#(
   parameter int  DEPTH = 16,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  cmd_t          wdata_i,
   input  logic [AW-1:0] raddr_i,
   output cmd_t          rdata_o
);

   cmd_t mem_q [DEPTH];
   cmd_t rdata_q;

   // write port and one-cycle read
   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Issues a loaded program of 12-bit ALU commands one at a time, handshaking
// on syscall/ready, capturing flags and counting failed CAS attempts.
// Optional feature macro: CAS_RETRY_EN (automatic reissue of a failed CAS).
module alu_cmd_sequencer
   import alu_cmd_pkg::*;
#(
   parameter int  DEPTH     = 16,
   parameter int  TIMEOUT   = 15,
   parameter int  MAX_RETRY = 3,
   localparam int AW        = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          load_we,
   input  logic [AW-1:0] load_addr,
   input  logic [11:0]   load_data,
   input  logic          start,
   input  logic [AW:0]   prog_len,
   input  logic          ready,
   input  logic          O,
   input  logic          C,
   input  logic          Z,
   input  logic          N,
   output logic [11:0]   command,
   output logic          syscall,
   output logic          busy,
   output logic          done,
   output logic          error,
   output logic [AW-1:0] pc,
   output logic [3:0]    flags_q,
   output logic [7:0]    cas_fail_cnt
);

   localparam int WW = $clog2(TIMEOUT + 1);

   state_e        state_q, state_d;
   logic [AW-1:0] pc_q, pc_d;
   logic [AW:0]   len_q, len_d;
   logic [AW:0]   pc_nxt;
   cmd_t          cmd_q, cmd_d;
   cmd_t          rdata;
   logic          syscall_q, syscall_d;
   logic          done_q, done_d;
   logic          error_q, error_d;
   logic          to_q, to_d;
   logic [WW-1:0] wcnt_q, wcnt_d;
   logic [3:0]    flags_r, flags_d;
   logic [7:0]    cnt_q, cnt_d;
   logic          advance;

`ifdef CAS_RETRY_EN
   localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
   logic [RW-1:0] retry_q, retry_d;
`endif

   // RAM address follows next-state pc so the word is ready while in FETCH
   cmd_prog_ram #(.DEPTH(DEPTH)) u_ram (
      .clk     (clk),
      .we_i    (load_we && (state_q == S_IDLE)),
      .waddr_i (load_addr),
      .wdata_i (cmd_t'(load_data)),
      .raddr_i (pc_d),
      .rdata_o (rdata)
   );

   assign pc_nxt = {1'b0, pc_q} + (AW+1)'(1);

   // next-state and output decode
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      len_d     = len_q;
      cmd_d     = cmd_q;
      syscall_d = 1'b0;
      done_d    = (state_q == S_DONE);
      error_d   = error_q;
      to_d      = 1'b0;
      wcnt_d    = wcnt_q;
      flags_d   = flags_r;
      cnt_d     = cnt_q;
      advance   = 1'b1;
`ifdef CAS_RETRY_EN
      retry_d   = retry_q;
`endif
      case (state_q)
         S_IDLE: if (start) begin
            error_d = 1'b0;
            if (prog_len == '0) begin
               state_d = S_DONE;
            end else begin
               state_d = S_FETCH;
               pc_d    = '0;
               cnt_d   = '0;
               len_d   = (prog_len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : prog_len;
`ifdef CAS_RETRY_EN
               retry_d = '0;
`endif
            end
         end
         S_FETCH: begin
            cmd_d   = rdata;
            state_d = S_ISSUE;
         end
         S_ISSUE: if (ready) begin
            syscall_d = 1'b1;
            wcnt_d    = '0;
            state_d   = S_WAIT;
         end
         S_WAIT: begin
            // first WAIT cycle sees the controller's stale ready level
            if (wcnt_q != '0 && ready) begin
               flags_d[FLAG_O] = O;
               flags_d[FLAG_C] = C;
               flags_d[FLAG_Z] = Z;
               flags_d[FLAG_N] = N;
               state_d = S_CHECK;
            end else if (wcnt_q == WW'(TIMEOUT - 1)) begin
               to_d    = 1'b1;
               state_d = S_DONE;
            end else begin
               wcnt_d = wcnt_q + 1'b1;
            end
         end
         S_CHECK: begin
            if (cmd_q.op == OP_CAS && !flags_r[FLAG_Z]) begin
               if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
`ifdef CAS_RETRY_EN
               if (retry_q < RW'(MAX_RETRY)) begin
                  retry_d = retry_q + 1'b1;
                  advance = 1'b0;
                  state_d = S_ISSUE;
               end
`endif
            end
            if (advance) begin
`ifdef CAS_RETRY_EN
               retry_d = '0;
`endif
               if (pc_nxt < len_q) begin
                  pc_d    = pc_nxt[AW-1:0];
                  state_d = S_FETCH;
               end else begin
                  state_d = S_DONE;
               end
            end
         end
         S_DONE: begin
            // error lands together with the done pulse
            error_d = error_q | to_q;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // state and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         pc_q      <= '0;
         len_q     <= '0;
         cmd_q     <= '0;
         syscall_q <= 1'b0;
         done_q    <= 1'b0;
         error_q   <= 1'b0;
         to_q      <= 1'b0;
         wcnt_q    <= '0;
         flags_r   <= '0;
         cnt_q     <= '0;
`ifdef CAS_RETRY_EN
         retry_q   <= '0;
`endif
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         len_q     <= len_d;
         cmd_q     <= cmd_d;
         syscall_q <= syscall_d;
         done_q    <= done_d;
         error_q   <= error_d;
         to_q      <= to_d;
         wcnt_q    <= wcnt_d;
         flags_r   <= flags_d;
         cnt_q     <= cnt_d;
`ifdef CAS_RETRY_EN
         retry_q   <= retry_d;
`endif
      end
   end

   assign command      = cmd_q;
   assign syscall      = syscall_q;
   assign busy         = (state_q != S_IDLE);
   assign done         = done_q;
   assign error        = error_q;
   assign pc           = pc_q;
   assign flags_q      = flags_r;
   assign cas_fail_cnt = cnt_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer: normal run, timeout, empty program,
// CAS failure handling, ignored busy writes, reset mid-run.
module tb_alu_cmd_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        load_we = 1'b0;
   logic [3:0]  load_addr = '0;
   logic [11:0] load_data = '0;
   logic        start = 1'b0;
   logic [4:0]  prog_len = '0;
   logic        ready = 1'b0;
   logic        O = 1'b0, C = 1'b0, Z = 1'b0, N = 1'b0;
   logic [11:0] command;
   logic        syscall, busy, done, error;
   logic [3:0]  pc;
   logic [3:0]  flags_q;
   logic [7:0]  cas_fail_cnt;

   alu_cmd_sequencer #(.DEPTH(16), .TIMEOUT(15), .MAX_RETRY(3)) dut (
      .clk(clk), .reset(reset), .load_we(load_we), .load_addr(load_addr),
      .load_data(load_data), .start(start), .prog_len(prog_len), .ready(ready),
      .O(O), .C(C), .Z(Z), .N(N), .command(command), .syscall(syscall),
      .busy(busy), .done(done), .error(error), .pc(pc), .flags_q(flags_q),
      .cas_fail_cnt(cas_fail_cnt)
   );

`ifdef CAS_RETRY_EN
   localparam int EXP_CAS = 4;
`else
   localparam int EXP_CAS = 1;
`endif

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int done_cnt = 0;
   logic [11:0] sc_cmd[$];
   int sc_cyc[$];

   always @(posedge clk) cyc <= cyc + 1;

   // record every issue pulse and done pulse
   always @(negedge clk) begin
      if (syscall) begin
         sc_cmd.push_back(command);
         sc_cyc.push_back(cyc);
      end
      if (done) done_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic load(input logic [3:0] a, input logic [11:0] d);
      load_we = 1'b1; load_addr = a; load_data = d;
      step(1);
      load_we = 1'b0;
   endtask

   task automatic kick(input logic [4:0] len);
      prog_len = len; start = 1'b1;
      step(1);
      start = 1'b0;
   endtask

   task automatic wait_done(input int bound, output int waited);
      waited = 0;
      while (!done && waited < bound) begin
         step(1);
         waited++;
      end
   endtask

   function automatic logic [11:0] sc_at(input int i);
      return (sc_cmd.size() > i) ? sc_cmd[i] : 12'h000;
   endfunction

   initial begin
      int b, b2, d0, w;
      step(3);
      check("rst_command", command, 12'h000);
      check("rst_ctrl", {syscall, busy, done, error}, 4'b0000);
      check("rst_pc", pc, 4'd0);
      check("rst_flags", flags_q, 4'h0);
      check("rst_cas", cas_fail_cnt, 8'd0);
      reset = 1'b0;
      load(4'd0, 12'h0C3);
      load(4'd1, 12'h251);

      // two-command program, ready always high
      ready = 1'b1; {O, C, Z, N} = 4'b0101;
      b = sc_cmd.size(); d0 = done_cnt;
      kick(5'd2);
      check("t1_busy", busy, 1'b1);
      check("t1_no_early_sc", syscall, 1'b0);
      step(1);
      check("t1_cmd_issue", command, 12'h0C3);
      check("t1_sc_before", syscall, 1'b0);
      step(1);
      check("t1_sc_t3", syscall, 1'b1);
      step(1);
      check("t1_sc_pulse", syscall, 1'b0);
      check("t1_cmd_hold", command, 12'h0C3);
      wait_done(40, w);
      check("t1_done_lat", w, 8);
      check("t1_done", done, 1'b1);
      check("t1_busy_low", busy, 1'b0);
      check("t1_err", error, 1'b0);
      check("t1_pc", pc, 4'd1);
      check("t1_flags", flags_q, 4'b0101);
      step(1);
      check("t1_done_pulse", done, 1'b0);
      check("t1_sc_count", sc_cmd.size() - b, 2);
      check("t1_sc0", sc_at(b), 12'h0C3);
      check("t1_sc1", sc_at(b + 1), 12'h251);
      check("t1_sc_gap", (sc_cyc.size() > b + 1) ? sc_cyc[b + 1] - sc_cyc[b] : 0, 5);
      check("t1_done_count", done_cnt - d0, 1);

      // timeout: ready drops after the first issue
      b = sc_cmd.size();
      kick(5'd2);
      step(2);
      check("t2_sc", syscall, 1'b1);
      ready = 1'b0;
      step(15);
      check("t2_pre_done", done, 1'b0);
      check("t2_pre_err", error, 1'b0);
      step(1);
      check("t2_done16", done, 1'b1);
      check("t2_err16", error, 1'b1);
      step(3);
      check("t2_sc_count", sc_cmd.size() - b, 1);
      check("t2_idle", busy, 1'b0);
      check("t2_err_sticky", error, 1'b1);

      // empty program
      ready = 1'b1;
      b = sc_cmd.size();
      kick(5'd0);
      check("t3_err_clr", error, 1'b0);
      check("t3_done_early", done, 1'b0);
      step(1);
      check("t3_done", done, 1'b1);
      step(2);
      check("t3_no_sc", sc_cmd.size() - b, 0);

      // CAS that always fails
      load(4'd0, 12'hE53);
      {O, C, Z, N} = 4'b0000;
      b = sc_cmd.size();
      kick(5'd1);
      wait_done(300, w);
      check("t4_done", done, 1'b1);
      step(1);
      check("t4_sc_count", sc_cmd.size() - b, EXP_CAS);
      check("t4_cas_cnt", cas_fail_cnt, EXP_CAS);
      check("t4_sc_cmd", sc_at(b), 12'hE53);
      check("t4_err", error, 1'b0);

      // write attempted while busy must be dropped
      load(4'd0, 12'h0C3);
      b = sc_cmd.size();
      kick(5'd1);
      load_we = 1'b1; load_addr = 4'd0; load_data = 12'hFFF;
      step(3);
      load_we = 1'b0;
      wait_done(40, w);
      step(1);
      b2 = sc_cmd.size();
      kick(5'd1);
      wait_done(40, w);
      check("t5_done", done, 1'b1);
      step(1);
      check("t5_first", sc_at(b), 12'h0C3);
      check("t5_rerun", sc_at(b2), 12'h0C3);
      check("t5_cas_cnt", cas_fail_cnt, 8'd0);

      // reset during the second command's WAIT
      b = sc_cmd.size();
      kick(5'd2);
      step(7);
      check("t6_sc2", syscall, 1'b1);
      check("t6_pc1", pc, 4'd1);
      reset = 1'b1;
      step(1);
      check("t6_sc_low", syscall, 1'b0);
      check("t6_busy_low", busy, 1'b0);
      check("t6_pc0", pc, 4'd0);
      check("t6_cmd0", command, 12'h000);
      reset = 1'b0;
      step(5);
      check("t6_no_more_sc", sc_cmd.size() - b, 2);
      b = sc_cmd.size();
      kick(5'd2);
      wait_done(60, w);
      check("t6_rerun_done", done, 1'b1);
      step(1);
      check("t6_rerun_count", sc_cmd.size() - b, 2);
      check("t6_rerun0", sc_at(b), 12'h0C3);
      check("t6_rerun1", sc_at(b + 1), 12'h251);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Command-issuing end of the ALU controller command interface. Holds a small loadable program of 12-bit commands (3-bit opcode, three 3-bit register addresses) and issues them one at a time: it drives `command`, pulses `syscall` and waits for the controller's `ready` before moving on. Flags returned by the ALU are captured per command. A failed compare-and-swap (opcode 111) can be retried automatically.

## Interface
- `DEPTH`, 16: program entries; power of two, 2..256.
- `TIMEOUT`, 15: maximum cycles waited for completion before error.
- `MAX_RETRY`, 3: CAS reissues after the first failure (used only with `CAS_RETRY_EN`).

- `clk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `load_we`  in  1  program write strobe.
- `load_addr`  in  $clog2(DEPTH)  program write address.
- `load_data`  in  12  program word.
- `start`  in  1  begin execution at entry 0.
- `prog_len`  in  $clog2(DEPTH)+1  number of entries to run; sampled on `start`.
- `ready`  in  1  controller idle/complete, level.
- `O`, `C`, `Z`, `N`  in  1 each  ALU flags; valid when `ready` rises.
- `command`  out  12  command word to controller.
- `syscall`  out  1  one-cycle issue pulse.
- `busy`  out  1  sequence in progress.
- `done`  out  1  one-cycle pulse when the sequence ends, whether it completed or failed.
- `error`  out  1  sticky timeout flag; cleared by `start` or `reset`.
- `pc`  out  $clog2(DEPTH)  index of the current or last issued entry.
- `flags_q`  out  4  {O,C,Z,N} of the last completed command.
- `cas_fail_cnt`  out  8  count of failed CAS attempts in this run; saturates at 255.

## Operation
- States:
  - IDLE:
    - `start` with `prog_len`=0 goes to DONE.
    - `start` with `prog_len`>0 goes to FETCH and sets pc=0, error=0, cas_fail_cnt=0.
  - FETCH: reads entry pc (RAM read latency 1), then goes to ISSUE.
  - ISSUE: waits for `ready`=1, then drives `syscall`=1 for one cycle and goes to WAIT.
  - WAIT:
    - The first WAIT cycle ignores `ready`.
    - After that, `ready`=1 latches flags_q and goes to CHECK.
    - Cycle count in WAIT reaching TIMEOUT sets `error` and goes to DONE.
  - CHECK:
    - Opcode 111 with Z=0 is a CAS failure. cas_fail_cnt increments, then see Configuration.
    - Otherwise, pc+1 < prog_len goes to FETCH with pc+1; else goes to DONE.
  - DONE: pulses `done` for one cycle, then goes to IDLE.
- `command` is registered. It is updated only on entering ISSUE and held stable through WAIT and CHECK.
- `busy`=1 in every state except IDLE.
- `load_we` writes only in IDLE. Writes in any other state are ignored.
- `start` outside IDLE is ignored.
- prog_len > DEPTH is clamped to DEPTH.
- pc never wraps; the sequence ends at the last entry.
- Reset values:
  - state IDLE.
  - `command`=0, `syscall`=0, `busy`=0, `done`=0, `error`=0.
  - `pc`=0, `flags_q`=0, `cas_fail_cnt`=0, retry counter 0.
  - Program RAM contents are not reset.
- Reset mid-operation: the next cycle is IDLE and `syscall` is low. No further commands are issued and RAM is retained.

## Timing
- `start` at cycle t: `syscall` is high at t+3 at the earliest (FETCH, RAM read, ISSUE), when `ready`=1.
- Per command, the minimum interval between successive `syscall` pulses is 5 cycles.
- `done` occurs 2 cycles after the final completion (CHECK, DONE).
- Timeout: `error` and `done` assert TIMEOUT+1 cycles after `syscall`.
- `ready` low during ISSUE stalls indefinitely. There is no timeout in ISSUE.

## Configuration
- `CAS_RETRY_EN` defined:
  - On a CAS failure with retry counter < MAX_RETRY, the counter increments and the state returns to ISSUE with the same pc and `command`.
  - Otherwise the counter clears and the sequence advances.
  - The counter also clears whenever pc advances.
- Not defined: a CAS failure only increments cas_fail_cnt and the sequence advances. No retry logic is synthesized.

## Structure
- Package `alu_cmd_pkg` holds:
  - opcode typedef (3 bits) and constants OP_SUB=3'b001, OP_CAS=3'b111.
  - a packed struct for the command word: op[11:9], a1[8:6], a2[5:3], a3[2:0].
  - the state enum.
  - the flag-vector bit positions.
- One sub-module, `cmd_prog_ram`: DEPTH×12 single write port, synchronous read port, no reset.

## Test plan
- Load {12'h0C3, 12'h251}, prog_len=2, `ready` held 1.
  - Expect exactly two `syscall` pulses carrying 12'h0C3 then 12'h251, with `command` stable between them.
  - Expect one `done`, `busy` low after it, error=0.
- `ready` stuck at 0 after the first `syscall`, TIMEOUT=15.
  - Expect error=1 and `done` 16 cycles after `syscall`, and no second `syscall`.
- CAS word 12'hE53 with Z=0 on every completion, CAS_RETRY_EN defined, MAX_RETRY=3.
  - Expect 4 `syscall` pulses, cas_fail_cnt=4, then `done`.
- The same CAS stimulus without the macro.
  - Expect 1 `syscall`, cas_fail_cnt=1, then `done`.
- `reset` asserted while in WAIT.
  - Expect `syscall`=0, busy=0 and pc=0 next cycle.
  - A subsequent `start` with no reload re-runs the retained program.
- `load_we` to entry 0 with 12'hFFF while busy.
  - Expect the write to be ignored: a re-run issues the original word.
- `start` with prog_len=0.
  - Expect `done` 2 cycles later and no `syscall`.
